ddr2_wr_dqs_sequencer: RTL and testbench
========================================

Name: ddr2_wr_dqs_sequencer

Overview:
- Write-path timing controller for the DDR2 controller.
- Turns accepted write commands into per-cycle strobe and data-path controls:
  - DQS preamble/postamble reset (ctrl_dqs_rst)
  - DQS tristate enable (ctrl_dqs_en)
  - DQ output enable (ctrl_wr_en)
  - write-data-FIFO read strobe (wdf_rd_en)
- Sits between the main command FSM and the per-byte DQS/DQ IOB instances, fanning out one copy per strobe group.

Parameters:
- DQS_WIDTH, 8, number of DQS groups; width of the replicated ctrl_dqs_rst/ctrl_dqs_en buses.
- WL_WIDTH, 4, width of wr_latency input.

Ports:
- clk  in  1  controller clock.
- reset  in  1  synchronous, active-high reset.
- wr_cmd_valid  in  1  write command request.
- wr_cmd_ready  out  1  command accepted when valid&ready at rising clk.
- burst_len_8  in  1  1 = BL8 (4 clk burst), 0 = BL4 (2 clk burst); sampled at acceptance.
- wr_latency  in  WL_WIDTH  write latency WL in clocks, legal 2..8; quasi-static, changed only while busy=0.
- ctrl_dqs_rst  out  DQS_WIDTH  1 = DQS driven low (pre/postamble/idle).
- ctrl_dqs_en  out  DQS_WIDTH  0 = DQS driver enabled, 1 = tristate.
- ctrl_wr_en  out  1  DQ output enable, high during burst cycles.
- wdf_rd_en  out  1  write-data FIFO pop, one cycle ahead of ctrl_wr_en.
- busy  out  1  any command outstanding or postamble in progress.
- odt_en  out  1  memory ODT drive (only with ODT_CTRL_EN).

Behaviour:
- Reset values, set on the cycle after reset is sampled high:
  - ctrl_dqs_rst = all 1, ctrl_dqs_en = all 1.
  - ctrl_wr_en = 0, wdf_rd_en = 0, busy = 0, wr_cmd_ready = 0.
  - odt_en = 0.
- Reset mid-operation discards all outstanding commands; no partial postamble.
- wr_cmd_ready goes 1 the first cycle after reset deasserts.
- Timeline for a command accepted at cycle A; B = 2 (BL4) or 4 (BL8); WL latched at A:
  - Preamble, cycle A+WL-1: ctrl_dqs_en = 0, ctrl_dqs_rst = 1.
  - Burst, cycles A+WL .. A+WL+B-1: ctrl_dqs_en = 0, ctrl_dqs_rst = 0, ctrl_wr_en = 1.
  - wdf_rd_en high during A+WL-1 .. A+WL+B-2, exactly B pulses.
  - Postamble, cycle A+WL+B: ctrl_dqs_en = 0, ctrl_dqs_rst = 1, ctrl_wr_en = 0.
  - Idle, from A+WL+B+1: ctrl_dqs_en = 1, ctrl_dqs_rst = 1.
- Internal states: IDLE, WAIT_WL, PREAMBLE, BURST, POSTAMBLE.
  - A one-deep pending slot holds a second command, each with its own WL countdown.
- Acceptance rule: wr_cmd_ready = 1 iff all of the following hold:
  - fewer than 2 commands outstanding (accepted, burst not finished);
  - at least B_prev clocks since the previous acceptance;
  - reset low.
- Back-to-back (next command accepted exactly B after previous):
  - Bursts abut with no gap.
  - Postamble and preamble are suppressed; ctrl_dqs_rst stays 0 and ctrl_wr_en stays 1 across the boundary.
- One-clock gap (accepted B+1 after previous):
  - The previous postamble cycle doubles as the next preamble.
  - ctrl_dqs_en stays 0 throughout.
- Larger gaps: full postamble, then tristate, then a fresh preamble.
- All DQS_WIDTH bits of ctrl_dqs_rst and ctrl_dqs_en are identical and registered. They change on the rising clk edge; the IOBs re-time them on the inverted clock.
- busy = 1 from the cycle after acceptance through the postamble cycle.
- wr_latency outside 2..8: saturated to the nearest legal value at acceptance.

Optional Feature:
- Macro: DDR2_WR_ODT_CTRL_EN.
- Defined:
  - odt_en port exists.
  - odt_en = 1 from cycle A+WL-3 (clamped to A+1 when WL < 4) through the postamble cycle.
  - odt_en stays high across merged/abutting bursts; it is 0 in reset.
- Undefined: odt_en port and logic are absent; all other timing is identical.

Decomposition:
- Shared package ddr2_ctrl_pkg holds:
  - state enum (IDLE, WAIT_WL, PREAMBLE, BURST, POSTAMBLE);
  - constants WL_MIN = 2, WL_MAX = 8, BURST_CLK_BL4 = 2, BURST_CLK_BL8 = 4.
- One natural sub-module, ddr2_wr_cmd_slot: holds the WL/burst-length countdown for one outstanding command. Instantiated twice (active, pending).

Test Plan:
- Single BL4 write, WL = 3, accepted at cycle 10:
  - preamble at 12 (en = 0, rst = 1); ctrl_wr_en high 13–14; wdf_rd_en high 12–13;
  - postamble at 15; idle at 16; busy 11–15.
- Back-to-back BL8 pair, WL = 5, accepted at 0 and 4:
  - ctrl_wr_en high continuously 5–12, rst = 0 throughout;
  - single preamble at 4, single postamble at 13; exactly 8 wdf_rd_en pulses.
- One-clock gap: BL4 at 0 and 3, WL = 2:
  - cycle 4 en = 0, rst = 1, serving as shared post/preamble;
  - bursts 2–3 and 5–6; en never 1 between 1 and 7.
- Outstanding limit: WL = 8, BL4, valid held high:
  - accepts at 0 and 2; ready low until the first burst completes at 9;
  - third command accepted at 10.
- Reset asserted during burst (WL = 4, accept at 0, reset at 5):
  - from 6: en = all 1, rst = all 1, ctrl_wr_en = 0, busy = 0;
  - no further wdf_rd_en pulses.
- With DDR2_WR_ODT_CTRL_EN, WL = 6, BL4 at 0:
  - odt_en high 3–8; with macro undefined, compiles without the port, other outputs identical.

Source files
------------

// File: rtl/ddr2_ctrl_pkg.sv
// Shared types and timing constants for the DDR2 controller write path.
// Burst lengths are expressed in controller clocks (two beats per clock).
package ddr2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WL,
    PREAMBLE,
    BURST,
    POSTAMBLE
  } state_t;

  localparam int WL_MIN        = 2;
  localparam int WL_MAX        = 8;
  localparam int BURST_CLK_BL4 = 2;
  localparam int BURST_CLK_BL8 = 4;
  localparam int ODT_LEAD      = 3;

  function automatic logic [2:0] burst_clks(input logic bl8);
    return bl8 ? 3'(BURST_CLK_BL8) : 3'(BURST_CLK_BL4);
  endfunction

endpackage

// File: rtl/ddr2_wr_cmd_slot.sv
// One outstanding write command: age since acceptance vs latched WL/BL.
// The odt_n1 lookahead exists only when DDR2_WR_ODT_CTRL_EN is defined.
module ddr2_wr_cmd_slot
  import ddr2_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_wl,
  input  logic [2:0] load_bl,
  output logic       active,
  output logic       done,
  output logic       burst_now,
  output logic       burst_n1,
  output logic       burst_n2
`ifdef DDR2_WR_ODT_CTRL_EN
  ,
  output logic       odt_n1
`endif
);

  state_t     state;
  logic       vld_q;
  logic [3:0] age_q;
  logic [3:0] wl_q;
  logic [2:0] bl_q;
  logic [4:0] age0;
  logic [4:0] age1;
  logic [4:0] age2;
  logic [4:0] wl5;
  logic [4:0] last;

  assign age0 = {1'b0, age_q};
  assign age1 = age0 + 5'd1;
  assign age2 = age0 + 5'd2;
  assign wl5  = {1'b0, wl_q};
  assign last = wl5 + {2'b00, bl_q} - 5'd1;

  always_comb begin
    state = IDLE;
    if (vld_q) begin
      unique case (1'b1)
        age0 >= wl5: state = BURST;
        age1 == wl5: state = PREAMBLE;
        default:     state = WAIT_WL;
      endcase
    end
  end

  assign active    = vld_q;
  assign burst_now = state == BURST;
  assign done      = burst_now && age0 == last;
  assign burst_n1  = state == PREAMBLE
                  || (burst_now && !done);
  assign burst_n2  = vld_q && age2 >= wl5
                  && age2 <= last;

`ifdef DDR2_WR_ODT_CTRL_EN
  assign odt_n1 = vld_q
               && age0 + 5'(ODT_LEAD + 1) >= wl5;
`endif

  // age counts clocks since acceptance; slot frees after its last burst clock
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      age_q <= 4'd0;
      wl_q  <= 4'(WL_MIN);
      bl_q  <= 3'(BURST_CLK_BL4);
    end else if (load) begin
      vld_q <= 1'b1;
      age_q <= 4'd1;
      wl_q  <= load_wl;
      bl_q  <= load_bl;
    end else if (done) begin
      vld_q <= 1'b0;
    end else if (vld_q) begin
      age_q <= age_q + 4'd1;
    end
  end

endmodule

// File: rtl/ddr2_wr_dqs_sequencer.sv
// Write-path DQS/DQ sequencer: two command slots, registered strobe controls.
// Define DDR2_WR_ODT_CTRL_EN to add the odt_en output and its window logic.
module ddr2_wr_dqs_sequencer
  import ddr2_ctrl_pkg::*;
#(
  parameter int DQS_WIDTH = 8,
  parameter int WL_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_cmd_valid,
  output logic                 wr_cmd_ready,
  input  logic                 burst_len_8,
  input  logic [WL_WIDTH-1:0]  wr_latency,
  output logic [DQS_WIDTH-1:0] ctrl_dqs_rst,
  output logic [DQS_WIDTH-1:0] ctrl_dqs_en,
  output logic                 ctrl_wr_en,
  output logic                 wdf_rd_en,
  output logic                 busy
`ifdef DDR2_WR_ODT_CTRL_EN
  ,
  output logic                 odt_en
`endif
);

  logic       ready_q;
  logic       accept;
  logic [3:0] wl_sat;
  logic [2:0] bl_new;
  logic [2:0] gap_q;
  logic [2:0] gap_next;
  logic [2:0] bprev_q;
  logic [2:0] bprev_next;
  logic [1:0] act;
  logic [1:0] done;
  logic [1:0] b_now;
  logic [1:0] b_n1;
  logic [1:0] b_n2;
  logic [1:0] load;
  logic [1:0] keep;
  logic       b0;
  logic       b1;
  logic       b2;
  logic       full_next;
  logic       gap_ok;
`ifdef DDR2_WR_ODT_CTRL_EN
  logic [1:0] odt_n1;
`endif

  assign wr_cmd_ready = ready_q & ~reset;
  assign accept       = wr_cmd_valid & wr_cmd_ready;
  assign bl_new       = burst_clks(burst_len_8);

  always_comb begin
    wl_sat = 4'(WL_MAX);
    if (wr_latency < WL_WIDTH'(WL_MIN))
      wl_sat = 4'(WL_MIN);
    else if (wr_latency <= WL_WIDTH'(WL_MAX))
      wl_sat = wr_latency[3:0];
  end

  assign load = {accept & act[0], accept & ~act[0]};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    ddr2_wr_cmd_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_wl   (wl_sat),
      .load_bl   (bl_new),
      .active    (act[i]),
      .done      (done[i]),
      .burst_now (b_now[i]),
      .burst_n1  (b_n1[i]),
      .burst_n2  (b_n2[i])
`ifdef DDR2_WR_ODT_CTRL_EN
      ,
      .odt_n1    (odt_n1[i])
`endif
    );
  end

  assign keep      = act & ~done;
  assign full_next = &keep | (accept & |keep);

  always_comb begin
    gap_next = gap_q;
    if (accept)
      gap_next = 3'd1;
    else if (gap_q != 3'd7)
      gap_next = gap_q + 3'd1;
  end

  assign bprev_next = accept ? bl_new : bprev_q;
  assign gap_ok     = gap_next >= bprev_next;

  // burst state now, one and two clocks ahead
  assign b0 = |b_now;
  assign b1 = |b_n1;
  assign b2 = |b_n2 | (accept & (wl_sat == 4'(WL_MIN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q      <= 1'b0;
      gap_q        <= 3'd7;
      bprev_q      <= 3'(BURST_CLK_BL4);
      ctrl_wr_en   <= 1'b0;
      wdf_rd_en    <= 1'b0;
      ctrl_dqs_rst <= '1;
      ctrl_dqs_en  <= '1;
      busy         <= 1'b0;
    end else begin
      ready_q      <= ~full_next & gap_ok;
      gap_q        <= gap_next;
      bprev_q      <= bprev_next;
      ctrl_wr_en   <= b1;
      wdf_rd_en    <= b2;
      ctrl_dqs_rst <= {DQS_WIDTH{~b1}};
      ctrl_dqs_en  <= {DQS_WIDTH{~(b0 | b1 | b2)}};
      busy         <= |keep | accept | b0;
    end
  end

`ifdef DDR2_WR_ODT_CTRL_EN
  always_ff @(posedge clk) begin
    if (reset)
      odt_en <= 1'b0;
    else
      odt_en <= |odt_n1
             | (accept & (wl_sat <= 4'(ODT_LEAD + 1)));
  end
`endif

endmodule

// File: tb/tb_ddr2_wr_dqs_sequencer.sv
// Randomized bench for ddr2_wr_dqs_sequencer against a command-list model.
// Honors DDR2_WR_ODT_CTRL_EN when defined.
module tb_ddr2_wr_dqs_sequencer;

  localparam int DQS_WIDTH = 8;
  localparam int WL_WIDTH  = 4;
  localparam int NCYC      = 4000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 wr_cmd_valid = 1'b0;
  logic                 wr_cmd_ready;
  logic                 burst_len_8 = 1'b0;
  logic [WL_WIDTH-1:0]  wr_latency = 4'd3;
  logic [DQS_WIDTH-1:0] ctrl_dqs_rst;
  logic [DQS_WIDTH-1:0] ctrl_dqs_en;
  logic                 ctrl_wr_en;
  logic                 wdf_rd_en;
  logic                 busy;
`ifdef DDR2_WR_ODT_CTRL_EN
  logic                 odt_en;
`endif

  always #5 clk = ~clk;

  ddr2_wr_dqs_sequencer #(
    .DQS_WIDTH (DQS_WIDTH),
    .WL_WIDTH  (WL_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_ready (wr_cmd_ready),
    .burst_len_8  (burst_len_8),
    .wr_latency   (wr_latency),
    .ctrl_dqs_rst (ctrl_dqs_rst),
    .ctrl_dqs_en  (ctrl_dqs_en),
    .ctrl_wr_en   (ctrl_wr_en),
    .wdf_rd_en    (wdf_rd_en),
    .busy         (busy)
`ifdef DDR2_WR_ODT_CTRL_EN
    ,
    .odt_en       (odt_en)
`endif
  );

  typedef struct {
    int a;
    int wl;
    int b;
  } cmd_t;

  cmd_t cmds[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input int cyc,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h want %h",
               tag, cyc, obs, exp);
    end
  endtask

  // burst covers A+WL .. A+WL+B-1
  function automatic bit burst_at(int x);
    foreach (cmds[i])
      if (x >= cmds[i].a + cmds[i].wl &&
          x <  cmds[i].a + cmds[i].wl + cmds[i].b)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int n_open(int c);
    int n = 0;
    foreach (cmds[i])
      if (cmds[i].a < c &&
          c < cmds[i].a + cmds[i].wl + cmds[i].b)
        n++;
    return n;
  endfunction

  function automatic bit busy_at(int c);
    foreach (cmds[i])
      if (c > cmds[i].a &&
          c <= cmds[i].a + cmds[i].wl + cmds[i].b)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit odt_at(int c);
    foreach (cmds[i]) begin
      int lo;
      lo = cmds[i].a + cmds[i].wl - 3;
      if (lo < cmds[i].a + 1) lo = cmds[i].a + 1;
      if (c >= lo && c <= cmds[i].a + cmds[i].wl + cmds[i].b)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int  last_a;
    int  last_b;
    bit  have_last;
    bit  prev_rst;
    int  mode;
    last_a    = 0;
    last_b    = 0;
    have_last = 1'b0;
    prev_rst  = 1'b1;
    mode      = 0;
    for (int c = 0; c < NCYC; c++) begin
      int   seg;
      int   w;
      bit   e_rdy;
      bit   e_bm1;
      bit   e_b0;
      bit   e_b1;
      cmd_t nc;
      @(posedge clk);
      #1;
      seg = c % 64;
      if (seg == 0) mode = $urandom_range(0, 2);
      if (seg == 12 && !busy_at(c) && $urandom_range(0, 2) != 0)
        wr_latency = 4'($urandom_range(0, 15));
      reset = (c < 3) || ($urandom_range(0, 199) == 0);
      if (seg < 12)
        wr_cmd_valid = 1'b0;
      else if (mode == 0)
        wr_cmd_valid = 1'b1;
      else if (mode == 1)
        wr_cmd_valid = 1'($urandom_range(0, 1));
      else
        wr_cmd_valid = ($urandom_range(0, 5) == 0);
      burst_len_8 = 1'($urandom_range(0, 1));

      e_rdy = !reset && !prev_rst && n_open(c) < 2 &&
              (!have_last || c - last_a >= last_b);
      e_bm1 = burst_at(c - 1);
      e_b0  = burst_at(c);
      e_b1  = burst_at(c + 1);

      @(negedge clk);
      check("ready", c, 32'(wr_cmd_ready), 32'(e_rdy));
      check("wr_en", c, 32'(ctrl_wr_en), 32'(e_b0));
      check("wdf_rd", c, 32'(wdf_rd_en), 32'(e_b1));
      check("dqs_rst", c, 32'(ctrl_dqs_rst),
            32'({DQS_WIDTH{!e_b0}}));
      check("dqs_en", c, 32'(ctrl_dqs_en),
            32'({DQS_WIDTH{!(e_bm1 || e_b0 || e_b1)}}));
      check("busy", c, 32'(busy), 32'(busy_at(c)));
`ifdef DDR2_WR_ODT_CTRL_EN
      check("odt", c, 32'(odt_en), 32'(odt_at(c)));
`endif

      if (reset) begin
        cmds.delete();
        have_last = 1'b0;
      end else if (wr_cmd_valid && e_rdy) begin
        w = int'(wr_latency);
        if (w < 2) w = 2;
        if (w > 8) w = 8;
        nc.a  = c;
        nc.wl = w;
        nc.b  = burst_len_8 ? 4 : 2;
        cmds.push_back(nc);
        last_a    = c;
        last_b    = nc.b;
        have_last = 1'b1;
      end
      prev_rst = reset;
      while (cmds.size() > 0 &&
             cmds[0].a + cmds[0].wl + cmds[0].b + 2 < c)
        void'(cmds.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
